// File: rtl/my_fifo_pkg.sv
// my_fifo_pkg: shared constants and helpers for the single-clock FIFO.
//   FIFO_MODE_STD  - registered read data, valid one cycle after rd_en
//   FIFO_MODE_FWFT - head of queue shown combinationally on dout
//   fifo_cnt_w     - width of an occupancy counter able to hold 0..depth
package my_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/my_fifo_ram.sv
// my_fifo_ram: DEPTH x WIDTH storage array, flop/LUT style.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address (asynchronous read)
//   rdata - read data, follows raddr combinationally
// Contents are intentionally not reset.
module my_fifo_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/my_sync_fifo.sv
// my_sync_fifo: parametrised single-clock FIFO with standard or FWFT read
// mode, almost-full/almost-empty flags, occupancy count and synchronous flush.
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - synchronous clear of pointers and count
//   din, wr_en          - write data / write request
//   rd_en               - read request (standard) or pop (FWFT)
//   dout                - read data
//   full, empty         - occupancy flags
//   almost_full         - count >= DEPTH-AF_OFFSET
//   almost_empty        - count <= AE_OFFSET
//   count               - current occupancy
//   wr_err, rd_err      - sticky overflow/underflow flags
// Build option: define MY_SYNC_FIFO_ERR_FLAGS_EN to generate the sticky error
// flags and overflow/underflow assertions; otherwise wr_err/rd_err are 0.
module my_sync_fifo
    import my_fifo_pkg::*;
#(
    parameter int WIDTH     = 9,
    parameter int DEPTH     = 512,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_OFFSET = 16,
    parameter int AE_OFFSET = 16,
    parameter int CW        = fifo_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             wr_err,
    output logic             rd_err
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             wr_ok, rd_ok;

    // Flags come from the registered count, so a write and read in the same
    // cycle are judged against the pre-edge state.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(DEPTH - AF_OFFSET));
    assign almost_empty = (count <= CW'(AE_OFFSET));

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    my_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok && !flush),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            if (wr_ok && !rd_ok)      count <= count + CW'(1);
            else if (rd_ok && !wr_ok) count <= count - CW'(1);
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head entry is always presented; meaningless while empty.
            assign dout = rd_data;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)               dout_q <= '0;
                else if (rd_ok && !flush) dout_q <= rd_data;
            end
            assign dout = dout_q;
        end
    endgenerate

`ifdef MY_SYNC_FIFO_ERR_FLAGS_EN
    // Sticky until reset; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            if (wr_en && full)  wr_err <= 1'b1;
            if (rd_en && empty) rd_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(wr_en && full))  else $warning("my_sync_fifo: write while full");
            assert (!(rd_en && empty)) else $warning("my_sync_fifo: read while empty");
        end
    end
`endif
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_my_sync_fifo.sv
// tb_my_sync_fifo: directed self-checking bench. Instance A is a standard-mode
// 8-deep FIFO (AF_OFFSET=2, AE_OFFSET=1); instance B is a 16-deep FWFT FIFO.
module tb_my_sync_fifo;

`ifdef MY_SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk, rst_n;

    logic       a_flush, a_wr, a_rd;
    logic [8:0] a_din, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_werr, a_rerr;
    logic [3:0] a_cnt;

    logic       b_flush, b_wr, b_rd;
    logic [8:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_werr, b_rerr;
    logic [4:0] b_cnt;

    int vectors = 0;
    int errs    = 0;

    my_sync_fifo #(.WIDTH(9), .DEPTH(8), .FWFT(0), .AF_OFFSET(2), .AE_OFFSET(1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .din(a_din), .wr_en(a_wr),
        .rd_en(a_rd), .dout(a_dout), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
        .wr_err(a_werr), .rd_err(a_rerr)
    );

    my_sync_fifo #(.WIDTH(9), .DEPTH(16), .FWFT(1), .AF_OFFSET(4), .AE_OFFSET(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .din(b_din), .wr_en(b_wr),
        .rd_en(b_rd), .dout(b_dout), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
        .wr_err(b_werr), .rd_err(b_rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_cnt"},   32'(a_cnt),   32'd0);
        chk({tag, "_empty"}, 32'(a_empty), 32'd1);
        chk({tag, "_full"},  32'(a_full),  32'd0);
        chk({tag, "_ae"},    32'(a_ae),    32'd1);
        chk({tag, "_af"},    32'(a_af),    32'd0);
        chk({tag, "_dout"},  32'(a_dout),  32'd0);
        chk({tag, "_werr"},  32'(a_werr),  32'd0);
        chk({tag, "_rerr"},  32'(a_rerr),  32'd0);
    endtask

    initial begin
        int wn, rn, ec;
        rst_n = 1'b0;
        a_flush = 0; a_wr = 0; a_rd = 0; a_din = '0;
        b_flush = 0; b_wr = 0; b_rd = 0; b_din = '0;
        tick(); tick();
        chk_a_reset("rst");
        chk("rst_b_cnt",   32'(b_cnt),   32'd0);
        chk("rst_b_empty", 32'(b_empty), 32'd1);
        rst_n = 1'b1;
        tick();

        // 1: write 1..5, then read them back one cycle after each rd_en
        for (int i = 1; i <= 5; i++) begin
            a_din = 9'(i); a_wr = 1;
            tick();
            chk("t1_cnt", 32'(a_cnt), 32'(i));
        end
        a_wr = 0;
        for (int i = 1; i <= 5; i++) begin
            a_rd = 1;
            tick();
            chk("t1_dout", 32'(a_dout), 32'(i));
            chk("t1_cnt_rd", 32'(a_cnt), 32'(5 - i));
        end
        chk("t1_empty", 32'(a_empty), 32'd1);
        // rejected read on empty: dout holds, rd_err per build
        tick();
        a_rd = 0;
        chk("t1_hold", 32'(a_dout), 32'h005);
        chk("t1_cnt0", 32'(a_cnt), 32'd0);
        chk("t1_rerr", 32'(a_rerr), 32'(ERR_EN));

        // 2: fill to 8, flags at thresholds
        for (int i = 1; i <= 8; i++) begin
            a_din = 9'(32'h10 + i); a_wr = 1;
            tick();
            chk("t2_cnt",  32'(a_cnt),  32'(i));
            chk("t2_ae",   32'(a_ae),   32'(i <= 1));
            chk("t2_af",   32'(a_af),   32'(i >= 6));
            chk("t2_full", 32'(a_full), 32'(i == 8));
        end
        a_din = 9'h1FF;
        tick();
        a_wr = 0;
        chk("t2_cnt9", 32'(a_cnt),  32'd8);
        chk("t2_full9", 32'(a_full), 32'd1);
        chk("t2_werr", 32'(a_werr), 32'(ERR_EN));

        // 3: read+write at full, write must be rejected
        a_din = 9'h1AA; a_wr = 1; a_rd = 1;
        tick();
        a_wr = 0;
        chk("t3_cnt", 32'(a_cnt), 32'd7);
        chk("t3_dout", 32'(a_dout), 32'h011);
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("t3_rd", 32'(a_dout), (j < 7) ? 32'h12 + 32'(j) : 32'h18);
        end
        a_rd = 0;
        chk("t3_empty", 32'(a_empty), 32'd1);

        // 6: flush with concurrent write
        for (int i = 1; i <= 3; i++) begin
            a_din = 9'(32'h20 + i); a_wr = 1;
            tick();
        end
        chk("t6_cnt3", 32'(a_cnt), 32'd3);
        a_flush = 1; a_din = 9'h1BB;
        tick();
        a_flush = 0; a_wr = 0;
        chk("t6_cnt", 32'(a_cnt), 32'd0);
        chk("t6_empty", 32'(a_empty), 32'd1);
        chk("t6_dout", 32'(a_dout), 32'h018);
        chk("t6_werr", 32'(a_werr), 32'(ERR_EN));
        a_din = 9'h031; a_wr = 1;
        tick();
        a_wr = 0; a_rd = 1;
        tick();
        a_rd = 0;
        chk("t6_post", 32'(a_dout), 32'h031);
        chk("t6_post_cnt", 32'(a_cnt), 32'd0);

        // mid-burst asynchronous reset
        a_wr = 1;
        for (int i = 0; i < 3; i++) begin
            a_din = 9'(32'h40 + i);
            tick();
        end
        a_rd = 1;
        tick();
        #2 rst_n = 1'b0;
        #1 chk_a_reset("mrst");
        tick();
        a_wr = 0; a_rd = 0;
        rst_n = 1'b1;
        tick();
        chk("mrst_cnt_after", 32'(a_cnt), 32'd0);

        // 4: FWFT, write into empty becomes visible next cycle
        b_din = 9'h0F3; b_wr = 1;
        tick();
        b_wr = 0;
        chk("t4_empty", 32'(b_empty), 32'd0);
        chk("t4_dout",  32'(b_dout),  32'h0F3);
        b_rd = 1;
        tick();
        b_rd = 0;
        chk("t4_empty2", 32'(b_empty), 32'd1);

        // 5: 20 words through 16 deep, 12 write, 8 write+read, 12 read
        wn = 0; rn = 0;
        for (int c = 0; c < 32; c++) begin
            b_wr = (c < 20);
            b_rd = (c >= 12);
            b_din = 9'(32'h100 + wn);
            if (b_rd) chk("t5_dout", 32'(b_dout), 32'h100 + 32'(rn));
            tick();
            if (b_wr) wn++;
            if (b_rd) rn++;
            ec = wn - rn;
            chk("t5_cnt", 32'(b_cnt), 32'(ec));
            chk("t5_le16", 32'(b_cnt <= 5'd16), 32'd1);
            chk("t5_af", 32'(b_af), 32'(ec >= 12));
        end
        b_wr = 0; b_rd = 0;
        chk("t5_empty", 32'(b_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
